// File: rtl/bk_add_seq.sv
// Multi-word adder sequencer sharing one external 4-bit slice, one nibble at a time.
// Optional build macro ADD_SEQ_CARRY_SKIP_EN skips the carry-injection pass when the carry is 0.
module bk_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  input  logic [4:0]             add_s
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_CARRY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef ADD_SEQ_CARRY_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cr_q, cr_d;
  logic [3:0]       partial_q, partial_d;
  logic             c1_q, c1_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cr_q        <= 1'b0;
      partial_q   <= '0;
      c1_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cr_q        <= cr_d;
      partial_q   <= partial_d;
      c1_q        <= c1_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: ADD forms the raw nibble sum, CARRY injects the chained carry.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cr_d      = cr_q;
    partial_d = partial_q;
    c1_d      = c1_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cr_d    = in_cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (SKIP_EN && !cr_q) begin
          sum_d[{idx_q, 2'b00} +: 4] = add_s[3:0];
          cr_d = add_s[4];
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ADD;
          end
        end else begin
          partial_d = add_s[3:0];
          c1_d      = add_s[4];
          state_d   = S_CARRY;
        end
      end
      S_CARRY: begin
        sum_d[{idx_q, 2'b00} +: 4] = add_s[3:0];
        cr_d = c1_q | add_s[4];
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Slice operands decode from registered state only.
  always_comb begin
    add_a = 4'h0;
    add_b = 4'h0;
    case (state_q)
      S_ADD: begin
        add_a = a_q[{idx_q, 2'b00} +: 4];
        add_b = b_q[{idx_q, 2'b00} +: 4];
      end
      S_CARRY: begin
        add_a = partial_q;
        add_b = {3'b000, cr_q};
      end
      default: begin
        add_a = 4'h0;
        add_b = 4'h0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cr_q;

endmodule

// File: tb/tb_bk_add_seq.sv
// Scoreboard bench for bk_add_seq: input monitor queues expected results, output monitor checks them.
module tb_bk_add_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic [4:0]   add_s;

  bk_add_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s)
  );

  // External 4-bit slice: plain addition with carry-out.
  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           rmode = 0;
  logic         vprev = 1'b0;
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random consumer backpressure unless a test drives out_ready by hand.
  initial forever begin
    @(posedge clk);
    #2;
    if (rmode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
`ifdef ADD_SEQ_CARRY_SKIP_EN
    int lat = 0;
    int c = int'(cin);
    for (int i = 0; i < int'(N); i++) begin
      int s;
      lat += (c != 0) ? 2 : 1;
      s = int'((a >> (4 * i)) & W'(15)) + int'((b >> (4 * i)) & W'(15)) + c;
      c = s / 16;
    end
    return lat;
`else
    return 2 * int'(N) + 0 * int'(a) + 0 * int'(b) + 0 * int'(cin);
`endif
  endfunction

  // Input monitor: every observed accept handshake queues its expected result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      logic [W:0] t;
      t = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      e.s   = t[W-1:0];
      e.c   = t[W];
      e.acc = cyc + 1;
      e.lat = exp_lat(in_a, in_b, in_cin);
      sb.push_back(e);
    end
  end

  // Output monitor: compare on first sight of a result, then require it stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev = 1'b0;
    end else begin
      if (out_valid) begin
        chk("ready_valid_exclusive", 32'(in_ready), 32'(0));
        if (!vprev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum %0h with no request pending", out_sum);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", 32'(out_sum), 32'(e.s));
            chk("cout", 32'(out_cout), 32'(e.c));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          hold_s = out_sum;
          hold_c = out_cout;
        end else begin
          chk("sum_stable", 32'(out_sum), 32'(hold_s));
          chk("cout_stable", 32'(out_cout), 32'(hold_c));
        end
      end
      vprev = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, out_valid=%0b, required none", sb.size(), out_valid);
      sb.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_sum"}, 32'(out_sum), 32'(0));
    chk({tag, "_out_cout"}, 32'(out_cout), 32'(0));
    chk({tag, "_add_a"}, 32'(add_a), 32'(0));
    chk({tag, "_add_b"}, 32'(add_b), 32'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed sum with slice operand trace.
    rmode = 0;
    send(W'(16'h1234), W'(16'h1111), 1'b0);
`ifndef ADD_SEQ_CARRY_SKIP_EN
    begin
      logic [W-1:0] ta;
      logic [W-1:0] tb;
      int           cr;
      ta = W'(16'h1234);
      tb = W'(16'h1111);
      cr = 0;
      for (int i = 0; i < int'(N); i++) begin
        int an;
        int bn;
        int s;
        an = int'((ta >> (4 * i)) & W'(15));
        bn = int'((tb >> (4 * i)) & W'(15));
        @(negedge clk);
        chk("trace_add_a", 32'(add_a), 32'(an));
        chk("trace_add_b", 32'(add_b), 32'(bn));
        @(negedge clk);
        chk("trace_carry_a", 32'(add_a), 32'((an + bn) % 16));
        chk("trace_carry_b", 32'(add_b), 32'(cr));
        s = an + bn + cr;
        cr = s / 16;
      end
      @(posedge clk);
      #1;
    end
`endif
    drain();

    send(W'(16'hFFFF), W'(16'h0001), 1'b0);
    drain();
    send(W'(16'h000F), W'(16'h0000), 1'b1);
    drain();
    send(W'(16'hFFFF), W'(16'h0000), 1'b1);
    drain();

    // Backpressure, then release with a back-to-back request.
    rmode = 1;
    out_ready = 1'b0;
    send(W'(16'h8765), W'(16'h4321), 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_a = W'(16'h0F0F);
    in_b = W'(16'hF0F1);
    in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'(1));
    chk("release_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_accepted", 32'(in_ready), 32'(0));
    rmode = 0;
    drain();

    // Reset in the middle of an operation.
    send(W'(16'h5555), W'(16'h7777), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_op_no_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_idle_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(W'(16'hABCD), W'(16'h1234), 1'b0);
    drain();

    // in_valid held high with operands changing every cycle.
    in_valid = 1'b1;
    repeat (2 * N + 6) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Randomized traffic including all-ones and zero operands.
    repeat (40) begin
      int k;
      k = int'($urandom_range(0, 3));
      ra = (k == 0) ? '1 : (k == 1) ? '0 : W'($urandom);
      k = int'($urandom_range(0, 3));
      rb = (k == 0) ? '1 : (k == 1) ? W'(1) : W'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb, 1'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
